skew_buf_bank: RTL and testbench
================================

// Module: skew_buf_bank
// PURPOSE
//  Parametrised bank of CHANNELS staggered delay lines feeding (skew) or draining (deskew) the systolic array.
//  Channel i delays its sample by D_i = BASE_DEPTH + i*STEP shift cycles (reverse: (CHANNELS-1-i)*STEP).
//  Adds a global stall, a synchronous flush and per-channel valid tracking.
//  Also adds an occupancy count so the array controller knows when the wavefront has drained.
// PARAMETERS
//  DATA_WIDTH  8   bits per channel sample
//  CHANNELS    16  number of independent delay lines
//  BASE_DEPTH  27  delay of the shortest line, in shift cycles (>=1)
//  STEP        1   extra delay per channel index (>=0)
//  (derived) D_MAX = BASE_DEPTH+(CHANNELS-1)*STEP; CNT_W = clog2(CHANNELS*D_MAX+1)
// PORTS
//  clk        in   1                 clock, all state on rising edge
//  rst_n      in   1                 asynchronous reset, active low
//  shift_en   in   1                 1: whole bank advances one slot; 0: bank frozen
//  flush      in   1                 synchronous clear of all valid bits and the count
//  mode_rev   in   1                 requested stagger direction (0 fwd, 1 rev)
//  in_valid   in   CHANNELS          per-channel input valid, 1 bit per channel
//  data_in    in   CHANNELS*DATA_W   channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//  out_valid  out  CHANNELS          per-channel output valid (registered)
//  data_out   out  CHANNELS*DATA_W   delayed samples (registered), same packing
//  occupancy  out  CNT_W             number of valid samples held in the bank
//  busy       out  1                 occupancy != 0
// BEHAVIOUR
//  Reset (rst_n=0, async): data_out=0, out_valid=0, occupancy=0, busy=0, mode=fwd, pointer=0.
//  Shift edge = rising edge with shift_en=1 and flush=0. Only shift edges move data.
//  Latency: sample captured on shift edge k appears on data_out/out_valid at shift edge k+D_i-1.
//   Visible from that edge until the next shift edge. D_i=1 => visible right after the capture edge.
//  Stall (shift_en=0): data_out, out_valid, contents, occupancy all hold; inputs ignored.
//  Valid travels with data: in_valid=0 inserts a bubble; out_valid[i]=0 for bubbles.
//   data_out for a bubble holds its last value.
//  Storage: per channel a D_MAX-entry circular buffer + 1 valid bit per entry.
//   One shared write pointer wraps D_MAX-1 -> 0.
//   Per-channel read offset D_i is selected from the latched mode.
//  Occupancy: next = occ + popcount(in_valid) - popcount(valids leaving) on shift edges.
//   Must never underflow or overflow; max value CHANNELS*D_MAX.
//  Flush: on the edge it is sampled, clears all stored valid bits, out_valid and occupancy.
//   Data bits are not cleared; the pointer is kept; same-cycle inputs are dropped.
//   Flush has priority over shift_en.
//  Mode latch: mode <= mode_rev only on an edge where occupancy==0 and in_valid==0 (or flush=1).
//   Otherwise the request is deferred, never partially applied, and contents are unaffected.
//  Reset mid-operation: immediate return to reset state; in-flight samples are lost.
// CONFIGURATION
//  SKEW_BUF_REVERSE_EN defined: mode_rev honoured per the mode-latch rule; reverse stagger available.
//  Not defined: mode_rev ignored, mode fixed fwd, no mode register or reverse offset muxes.
//   All other behaviour is identical.
// STRUCTURE
//  Package skew_buf_pkg: clog2 function, D_MAX/CNT_W/pointer-width derivation functions.
//   Also holds localparams MODE_FWD=1'b0, MODE_REV=1'b1.
//  Sub-module skew_buf_chan: one circular delay line + valid bits; inputs ptr, offset, shift, flush.
//   Instantiated CHANNELS times in a generate loop.
//  Top level holds the shared pointer, the mode register and the occupancy counter.
// TESTING (defaults: W=8, N=16, BASE=27, STEP=1)
//  1 Fwd latency: shift_en=1, in_valid=16'h0001, data_in[7:0]=8'hA5 once.
//    -> out_valid[0]=1, data_out[7:0]=A5 exactly 27 edges later for 1 cycle.
//    Same on channel 15 -> 42 edges later; occupancy 1 -> 0 at the exit edge.
//  2 Stall: inject on ch0, drop shift_en for 5 cycles mid-flight -> exit at 27+5 clock edges.
//    Outputs frozen during the stall.
//  3 Full load: all channels valid for 50 shift edges -> occupancy peaks at sum(D_i)=552.
//    No over/underflow; streaming values exit in order with no gaps.
//  4 Flush: load 10 samples, assert flush together with in_valid=16'hFFFF.
//    -> next edge occupancy=0, out_valid=0; no sample ever emerges.
//  5 Reverse (macro on): mode_rev=1 while occupancy=3 -> mode stays fwd until the bank drains.
//    Then ch0 delay 42, ch15 delay 27.
//  6 Async reset asserted mid-stream without a clock edge -> all outputs 0 immediately.
//    After release the first sample behaves as in test 1.

Source files
------------

// File: rtl/skew_buf_pkg.sv
// Shared constants and elaboration-time helpers for the skew buffer bank.
// Derives line depth, occupancy counter width and pointer width from the bank parameters.
package skew_buf_pkg;

  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_REV = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

  function automatic int calc_d_max(input int channels, input int base_depth, input int step);
    return base_depth + (channels - 1) * step;
  endfunction

  function automatic int calc_cnt_w(input int channels, input int d_max);
    return clog2(channels * d_max + 1);
  endfunction

  // A single-entry line still needs a one-bit pointer to stay a legal vector.
  function automatic int calc_ptr_w(input int d_max);
    return (d_max > 1) ? clog2(d_max) : 1;
  endfunction

endpackage

// File: rtl/skew_buf_if.sv
// Signal bundle between the array controller (master) and skew_buf_bank (slave).
interface skew_buf_if
  import skew_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 16,
  parameter int CNT_W      = calc_cnt_w(16, calc_d_max(16, 27, 1))
);
  logic                           shift_en;
  logic                           flush;
  logic                           mode_rev;
  logic [CHANNELS-1:0]            in_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] data_in;
  logic [CHANNELS-1:0]            out_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] data_out;
  logic [CNT_W-1:0]               occupancy;
  logic                           busy;

  modport master (
    output shift_en, flush, mode_rev, in_valid, data_in,
    input  out_valid, data_out, occupancy, busy
  );

  modport slave (
    input  shift_en, flush, mode_rev, in_valid, data_in,
    output out_valid, data_out, occupancy, busy
  );

endinterface

// File: rtl/skew_buf_chan.sv
// One delay line: D_MAX-entry circular data store plus a valid bit per entry.
// The output register loads the entry written 'offset' shift edges earlier (offset 0 bypasses storage).
module skew_buf_chan
  import skew_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int D_MAX      = 42,
  parameter int PTR_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift,
  input  logic                  flush,
  input  logic [PTR_W-1:0]      ptr,
  input  logic [PTR_W-1:0]      offset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic [DATA_WIDTH-1:0] data_mem [D_MAX];
  logic [D_MAX-1:0]      valid_mem;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // Modular subtraction stays correct even when ptr + D_MAX wraps the pointer width.
  always_comb begin
    rd_ptr   = (ptr >= offset) ? (ptr - offset) : (ptr + PTR_W'(D_MAX) - offset);
    rd_valid = in_valid;
    rd_data  = data_in;
    if (offset != '0) begin
      rd_valid = valid_mem[rd_ptr];
      rd_data  = data_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (shift) data_mem[ptr] <= data_in;
  end

  // A consumed entry drops its valid bit so a later direction change cannot replay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (flush) begin
      valid_mem <= '0;
      out_valid <= 1'b0;
    end else if (shift) begin
      if (offset != '0) valid_mem[rd_ptr] <= 1'b0;
      valid_mem[ptr] <= in_valid;
      out_valid      <= rd_valid;
      if (rd_valid) data_out <= rd_data;
    end
  end

endmodule

// File: rtl/skew_buf_bank.sv
// Bank of CHANNELS staggered delay lines with shared write pointer, stall, flush and occupancy count.
// Define SKEW_BUF_REVERSE_EN to honour mode_rev (reverse stagger); otherwise the bank is forward-only.
module skew_buf_bank
  import skew_buf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 16,
  parameter int BASE_DEPTH = 27,
  parameter int STEP       = 1
) (
  input logic       clk,
  input logic       rst_n,
  skew_buf_if.slave bus
);

  localparam int D_MAX = calc_d_max(CHANNELS, BASE_DEPTH, STEP);
  localparam int CNT_W = calc_cnt_w(CHANNELS, D_MAX);
  localparam int PTR_W = calc_ptr_w(D_MAX);

  logic                           shift;
  logic [PTR_W-1:0]               wr_ptr;
  logic [CNT_W-1:0]               occ;
  logic [CNT_W-1:0]               in_cnt;
  logic [CNT_W-1:0]               out_cnt;
  logic [CHANNELS-1:0]            chan_valid;
  logic [CHANNELS*DATA_WIDTH-1:0] chan_data;

  assign shift = bus.shift_en && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (shift) begin
      wr_ptr <= (wr_ptr == PTR_W'(D_MAX - 1)) ? '0 : wr_ptr + 1'b1;
    end
  end

`ifdef SKEW_BUF_REVERSE_EN
  logic mode;

  // Direction changes only while the bank is empty, so no sample ever sees two offsets.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= MODE_FWD;
    end else if (bus.flush || (occ == '0 && bus.in_valid == '0)) begin
      mode <= bus.mode_rev;
    end
  end
`else
  logic unused_mode_rev;
  assign unused_mode_rev = bus.mode_rev;
`endif

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    localparam int FWD_OFF = BASE_DEPTH + i * STEP - 1;
    logic [PTR_W-1:0] offset;

`ifdef SKEW_BUF_REVERSE_EN
    localparam int REV_OFF = BASE_DEPTH + (CHANNELS - 1 - i) * STEP - 1;
    assign offset = (mode == MODE_REV) ? PTR_W'(REV_OFF) : PTR_W'(FWD_OFF);
`else
    assign offset = PTR_W'(FWD_OFF);
`endif

    skew_buf_chan #(
      .DATA_WIDTH (DATA_WIDTH),
      .D_MAX      (D_MAX),
      .PTR_W      (PTR_W)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift     (shift),
      .flush     (bus.flush),
      .ptr       (wr_ptr),
      .offset    (offset),
      .in_valid  (bus.in_valid[i]),
      .data_in   (bus.data_in[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_valid (chan_valid[i]),
      .data_out  (chan_data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Samples on the output registers still count as held; they leave on the next shift edge.
  always_comb begin
    in_cnt  = '0;
    out_cnt = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_cnt  = in_cnt + CNT_W'(bus.in_valid[i]);
      out_cnt = out_cnt + CNT_W'(chan_valid[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (bus.flush) begin
      occ <= '0;
    end else if (bus.shift_en) begin
      occ <= occ + in_cnt - out_cnt;
    end
  end

  assign bus.out_valid = chan_valid;
  assign bus.data_out  = chan_data;
  assign bus.occupancy = occ;
  assign bus.busy      = (occ != '0);

endmodule

// File: tb/tb_skew_buf_bank.sv
// Self-checking bench for skew_buf_bank against a time-indexed behavioural model of the stagger.
// Honours SKEW_BUF_REVERSE_EN the same way the design does.
module tb_skew_buf_bank;
  import skew_buf_pkg::*;

  localparam int DW    = 8;
  localparam int CH    = 16;
  localparam int BASE  = 27;
  localparam int STEP  = 1;
  localparam int D_MAX = calc_d_max(CH, BASE, STEP);
  localparam int CNT_W = calc_cnt_w(CH, D_MAX);
  localparam int SUM_D = CH * BASE + STEP * CH * (CH - 1) / 2;
  localparam int MAXS  = 4096;
`ifdef SKEW_BUF_REVERSE_EN
  localparam bit REV_EN = 1'b1;
`else
  localparam bit REV_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  skew_buf_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .CNT_W(CNT_W)) bus ();

  skew_buf_bank #(
    .DATA_WIDTH (DW),
    .CHANNELS   (CH),
    .BASE_DEPTH (BASE),
    .STEP       (STEP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  // Model: every capture is recorded by shift-edge number; a sample on channel ch captured at
  // edge k is shown from edge k+D-1 until the next shift edge, then it is gone.
  bit             m_hv   [CH][MAXS];
  logic [DW-1:0]  m_hd   [CH][MAXS];
  int             m_s;
  int             m_floor;
  int             m_inflight;
  logic [CH-1:0]  m_ov;
  logic [DW-1:0]  m_do   [CH];
  bit             m_mode;

  function automatic int delay_of(input int ch, input bit mode);
    return BASE + (mode ? (CH - 1 - ch) : ch) * STEP;
  endfunction

  function automatic logic [CH*DW-1:0] model_data();
    logic [CH*DW-1:0] v;
    for (int c = 0; c < CH; c++) v[c*DW +: DW] = m_do[c];
    return v;
  endfunction

  function automatic int model_occ();
    return m_inflight + $countones(m_ov);
  endfunction

  task automatic model_reset();
    m_floor    = m_s;
    m_inflight = 0;
    m_ov       = '0;
    m_mode     = 1'b0;
    for (int c = 0; c < CH; c++) m_do[c] = '0;
  endtask

  task automatic tick();
    int  d;
    int  k;
    bit  latch;
    latch = bus.flush || (model_occ() == 0 && bus.in_valid == '0);
    if (bus.flush) begin
      m_floor    = m_s;
      m_inflight = 0;
      m_ov       = '0;
    end else if (bus.shift_en) begin
      if (m_s >= MAXS - 2) begin
        $display("[TB] FAIL model_history exhausted at edge %0d", m_s);
        $fatal(1, "[TB] model history");
      end
      m_s = m_s + 1;
      for (int c = 0; c < CH; c++) begin
        m_hv[c][m_s] = bus.in_valid[c];
        m_hd[c][m_s] = bus.data_in[c*DW +: DW];
        if (bus.in_valid[c]) m_inflight++;
      end
      for (int c = 0; c < CH; c++) begin
        d = delay_of(c, m_mode);
        k = m_s - d + 1;
        if (k > m_floor && m_hv[c][k]) begin
          m_ov[c]    = 1'b1;
          m_do[c]    = m_hd[c][k];
          m_hv[c][k] = 1'b0;
          m_inflight--;
        end else begin
          m_ov[c] = 1'b0;
        end
      end
    end
    if (REV_EN && latch) m_mode = bus.mode_rev;
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.shift_en = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = '0;
    bus.data_in  = '0;
  endtask

  task automatic inject_and_measure(input int ch, input logic [DW-1:0] val,
                                    output int lat, output logic [DW-1:0] seen);
    go_idle();
    bus.in_valid[ch]          = 1'b1;
    bus.data_in[ch*DW +: DW]  = val;
    tick();
    lat = 1;
    go_idle();
    while (!bus.out_valid[ch] && lat < 100) begin
      tick();
      lat++;
    end
    seen = bus.data_out[ch*DW +: DW];
    if (lat >= 100) lat = -1;
  endtask

  task automatic drain();
    int n;
    go_idle();
    n = 0;
    while (bus.occupancy != '0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (bus.occupancy !== '0) begin
      failures++;
      $display("[TB] FAIL drain occupancy=%0d required=0", bus.occupancy);
    end
    tick();
  endtask

  task automatic test_reset();
    bus.shift_en = 1'b0;
    bus.flush    = 1'b0;
    bus.mode_rev = 1'b0;
    bus.in_valid = '0;
    bus.data_in  = '0;
    rst_n        = 1'b0;
    m_s          = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== '0) begin
      failures++;
      $display("[TB] FAIL reset_out_valid got=%h required=0", bus.out_valid);
    end
    checks++;
    if (bus.data_out !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data_out got=%h required=0", bus.data_out);
    end
    checks++;
    if (bus.occupancy !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_occupancy got=%0d busy=%b required=0/0", bus.occupancy, bus.busy);
    end
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fwd_latency();
    int            lat;
    logic [DW-1:0] seen;
    for (int pass = 0; pass < 2; pass++) begin
      int ch;
      ch = (pass == 0) ? 0 : CH - 1;
      inject_and_measure(ch, 8'hA5, lat, seen);
      checks++;
      if (lat !== BASE + ch * STEP || seen !== 8'hA5) begin
        failures++;
        $display("[TB] FAIL fwd_latency ch%0d got lat=%0d data=%h required lat=%0d data=a5",
                 ch, lat, seen, BASE + ch * STEP);
      end
      checks++;
      if (bus.occupancy !== CNT_W'(1) || bus.busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL fwd_occ_visible ch%0d got=%0d required=1", ch, bus.occupancy);
      end
      tick();
      checks++;
      if (bus.occupancy !== '0 || bus.out_valid !== '0 || bus.data_out[ch*DW +: DW] !== 8'hA5) begin
        failures++;
        $display("[TB] FAIL fwd_exit ch%0d occ=%0d ov=%h data=%h required occ=0 ov=0 data=a5",
                 ch, bus.occupancy, bus.out_valid, bus.data_out[ch*DW +: DW]);
      end
    end
  endtask

  task automatic test_stall();
    int edges;
    go_idle();
    bus.in_valid[0]  = 1'b1;
    bus.data_in[7:0] = 8'h3C;
    tick();
    edges = 1;
    go_idle();
    repeat (9) begin
      tick();
      edges++;
    end
    bus.shift_en = 1'b0;
    repeat (5) begin
      bus.in_valid = CH'($urandom);
      bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
      edges++;
      checks++;
      if (bus.occupancy !== CNT_W'(1) || bus.out_valid !== m_ov || bus.data_out !== model_data()) begin
        failures++;
        $display("[TB] FAIL stall_hold occ=%0d ov=%h required occ=1 ov=%h", bus.occupancy,
                 bus.out_valid, m_ov);
      end
    end
    go_idle();
    while (!bus.out_valid[0] && edges < 200) begin
      tick();
      edges++;
    end
    checks++;
    if (edges !== BASE + 5 || bus.data_out[7:0] !== 8'h3C) begin
      failures++;
      $display("[TB] FAIL stall_latency got edges=%0d data=%h required edges=%0d data=3c",
               edges, bus.data_out[7:0], BASE + 5);
    end
    drain();
  endtask

  task automatic test_full_load();
    int peak;
    int n;
    peak = 0;
    go_idle();
    for (int t = 0; t < 50 + 100; t++) begin
      if (t < 50) begin
        bus.in_valid = '1;
        bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        go_idle();
      end
      tick();
      if (int'(bus.occupancy) > peak) peak = int'(bus.occupancy);
      checks++;
      if (bus.out_valid !== m_ov || bus.data_out !== model_data() ||
          bus.occupancy !== CNT_W'(model_occ()) || bus.busy !== (model_occ() != 0)) begin
        failures++;
        $display("[TB] FAIL full_load t=%0d ov=%h/%h occ=%0d/%0d data=%h/%h", t, bus.out_valid,
                 m_ov, bus.occupancy, model_occ(), bus.data_out, model_data());
      end
      if (t >= 50 && bus.occupancy == '0) break;
    end
    checks++;
    if (peak !== SUM_D) begin
      failures++;
      $display("[TB] FAIL full_peak got=%0d required=%0d", peak, SUM_D);
    end
    n = 0;
    drain();
  endtask

  task automatic test_flush();
    go_idle();
    for (int t = 0; t < 10; t++) begin
      bus.in_valid = '0;
      bus.in_valid[$urandom_range(CH - 1)] = 1'b1;
      bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    checks++;
    if (bus.occupancy !== CNT_W'(10)) begin
      failures++;
      $display("[TB] FAIL flush_preload got=%0d required=10", bus.occupancy);
    end
    bus.flush    = 1'b1;
    bus.in_valid = '1;
    tick();
    checks++;
    if (bus.occupancy !== '0 || bus.out_valid !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL flush_clear occ=%0d ov=%h busy=%b required 0/0/0", bus.occupancy,
               bus.out_valid, bus.busy);
    end
    go_idle();
    for (int t = 0; t < D_MAX + 5; t++) begin
      tick();
      checks++;
      if (bus.out_valid !== '0 || bus.occupancy !== '0) begin
        failures++;
        $display("[TB] FAIL flush_ghost t=%0d ov=%h occ=%0d required 0/0", t, bus.out_valid,
                 bus.occupancy);
      end
    end
  endtask

  task automatic test_reverse();
    int            lat;
    logic [DW-1:0] seen;
    bus.mode_rev = 1'b0;
    drain();
    for (int j = 0; j < 3; j++) begin
      go_idle();
      bus.in_valid[0]  = 1'b1;
      bus.data_in[7:0] = 8'h10 + 8'(j);
      tick();
    end
    go_idle();
    bus.mode_rev = 1'b1;
    checks++;
    if (bus.occupancy !== CNT_W'(3)) begin
      failures++;
      $display("[TB] FAIL rev_preload got=%0d required=3", bus.occupancy);
    end
    lat = 3;
    while (!bus.out_valid[0] && lat < 100) begin
      tick();
      lat++;
    end
    checks++;
    if (lat !== BASE || bus.data_out[7:0] !== 8'h10) begin
      failures++;
      $display("[TB] FAIL rev_deferred got lat=%0d data=%h required lat=%0d data=10", lat,
               bus.data_out[7:0], BASE);
    end
    drain();
    inject_and_measure(0, 8'h5A, lat, seen);
    checks++;
    if (lat !== (REV_EN ? D_MAX : BASE) || seen !== 8'h5A) begin
      failures++;
      $display("[TB] FAIL rev_ch0 got lat=%0d data=%h required lat=%0d data=5a", lat, seen,
               REV_EN ? D_MAX : BASE);
    end
    drain();
    inject_and_measure(CH - 1, 8'hC3, lat, seen);
    checks++;
    if (lat !== (REV_EN ? BASE : D_MAX) || seen !== 8'hC3) begin
      failures++;
      $display("[TB] FAIL rev_ch15 got lat=%0d data=%h required lat=%0d data=c3", lat, seen,
               REV_EN ? BASE : D_MAX);
    end
    bus.mode_rev = 1'b0;
    drain();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      bus.shift_en = ($urandom_range(7) != 0);
      bus.flush    = ($urandom_range(63) == 0);
      bus.in_valid = CH'($urandom) & CH'($urandom);
      bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(7) == 0) bus.in_valid = '0;
      if ($urandom_range(39) == 0) bus.mode_rev = ~bus.mode_rev;
      tick();
      checks++;
      if (bus.out_valid !== m_ov || bus.data_out !== model_data() ||
          bus.occupancy !== CNT_W'(model_occ()) || bus.busy !== (model_occ() != 0)) begin
        failures++;
        $display("[TB] FAIL random t=%0d ov=%h/%h occ=%0d/%0d data=%h/%h", t, bus.out_valid,
                 m_ov, bus.occupancy, model_occ(), bus.data_out, model_data());
      end
    end
    bus.mode_rev = 1'b0;
    drain();
  endtask

  task automatic test_async_reset();
    int            lat;
    logic [DW-1:0] seen;
    go_idle();
    for (int t = 0; t < 30; t++) begin
      bus.in_valid = CH'($urandom);
      bus.data_in  = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
    go_idle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== '0 || bus.data_out !== '0) begin
      failures++;
      $display("[TB] FAIL async_reset_outputs ov=%h data=%h required 0/0", bus.out_valid,
               bus.data_out);
    end
    checks++;
    if (bus.occupancy !== '0 || bus.busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL async_reset_occ occ=%0d busy=%b required 0/0", bus.occupancy, bus.busy);
    end
    #2 rst_n = 1'b1;
    model_reset();
    inject_and_measure(0, 8'hA5, lat, seen);
    checks++;
    if (lat !== BASE || seen !== 8'hA5) begin
      failures++;
      $display("[TB] FAIL post_reset_latency got lat=%0d data=%h required lat=%0d data=a5", lat,
               seen, BASE);
    end
    drain();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_fwd_latency();
    test_stall();
    test_full_load();
    test_flush();
    test_reverse();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
